// File: rtl/systolic_chain_if.sv
// ============================================================================
// Module      : systolic_chain_if
// Description : TinyTapeout-style tile pins (enable, data, control, readout)
//               bundled for the systolic MAC chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface systolic_chain_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

`default_nettype wire

// File: rtl/systolic_chain.sv
// ============================================================================
// Module      : systolic_chain
// Description : Weight-stationary 1-D chain of signed 8x8 MAC PEs with a
//               byte-muxed accumulator readout. Optional macro
//               SYSTOLIC_SATURATE_EN selects saturating accumulation with a
//               sticky overflow flag; otherwise accumulators wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_chain #(
    parameter int NUM_PE = 4,
    parameter int ACC_W  = 24
) (
    input  wire logic         clk,
    input  wire logic         rst,
    systolic_chain_if.slave   io_tile
);

    localparam logic [1:0] c_OP_NOP    = 2'b00;
    localparam logic [1:0] c_OP_LOAD_W = 2'b01;
    localparam logic [1:0] c_OP_STREAM = 2'b10;
    localparam logic [1:0] c_OP_CLEAR  = 2'b11;

    logic signed [7:0]       r_w   [NUM_PE];
    logic signed [7:0]       r_a   [NUM_PE];
    logic signed [ACC_W-1:0] r_acc [NUM_PE];
    logic [NUM_PE-1:0]       r_v;
    logic                    r_ovf;

    logic [1:0] w_op;
    logic [1:0] w_sel_pe;
    logic [1:0] w_sel_byte;
    logic       w_unused;

    assign w_op       = io_tile.uio_in[1:0];
    assign w_sel_pe   = io_tile.uio_in[3:2];
    assign w_sel_byte = io_tile.uio_in[5:4];
    assign w_unused   = &{1'b0, io_tile.uio_in[7:6], c_OP_NOP};

    logic signed [15:0]      w_prod    [NUM_PE];
    logic signed [ACC_W-1:0] w_acc_nxt [NUM_PE];
    logic                    w_set_ovf;

`ifdef SYSTOLIC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic signed [ACC_W:0] w_wide [NUM_PE];
`endif

    always_comb begin
        w_set_ovf = 1'b0;
        for (int i = 0; i < NUM_PE; i++) begin
            w_prod[i] = r_a[i] * r_w[i];
`ifdef SYSTOLIC_SATURATE_EN
            // One guard bit exposes overflow as a mismatch of the top two bits.
            w_wide[i] = (ACC_W+1)'(r_acc[i]) + (ACC_W+1)'(w_prod[i]);
            if (w_wide[i][ACC_W] != w_wide[i][ACC_W-1]) begin
                w_acc_nxt[i] = w_wide[i][ACC_W] ? c_ACC_MIN : c_ACC_MAX;
                if (r_v[i]) begin
                    w_set_ovf = 1'b1;
                end
            end else begin
                w_acc_nxt[i] = w_wide[i][ACC_W-1:0];
            end
`else
            w_acc_nxt[i] = r_acc[i] + ACC_W'(w_prod[i]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PE; i++) begin
                r_w[i]   <= '0;
                r_a[i]   <= '0;
                r_acc[i] <= '0;
            end
            r_v   <= '0;
            r_ovf <= 1'b0;
        end else if (io_tile.ena) begin
            if (w_op == c_OP_STREAM) begin
                r_a[0] <= io_tile.ui_in;
            end
            for (int i = 1; i < NUM_PE; i++) begin
                r_a[i] <= r_a[i-1];
            end

            if (w_op == c_OP_LOAD_W) begin
                r_w[0] <= io_tile.ui_in;
                for (int i = 1; i < NUM_PE; i++) begin
                    r_w[i] <= r_w[i-1];
                end
            end

            // CLEAR wins over MAC and drops every in-flight activation.
            if (w_op == c_OP_CLEAR) begin
                r_v   <= '0;
                r_ovf <= 1'b0;
                for (int i = 0; i < NUM_PE; i++) begin
                    r_acc[i] <= '0;
                end
            end else begin
                r_v[0] <= (w_op == c_OP_STREAM);
                for (int i = 1; i < NUM_PE; i++) begin
                    r_v[i] <= r_v[i-1];
                end
                for (int i = 0; i < NUM_PE; i++) begin
                    if (r_v[i]) begin
                        r_acc[i] <= w_acc_nxt[i];
                    end
                end
                if (w_set_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Readout view: four slots, absent PEs read as zero.
    logic [23:0] w_rd_acc [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_rd
        if (gi < NUM_PE) begin : g_live
            assign w_rd_acc[gi] = 24'(r_acc[gi]);
        end else begin : g_absent
            assign w_rd_acc[gi] = '0;
        end
    end

    logic       w_busy;
    logic [7:0] w_status;
    logic [7:0] w_rd_byte;

    assign w_busy   = |r_v;
    assign w_status = {r_ovf, w_busy, 6'b0};

    always_comb begin
        w_rd_byte = 8'h00;
        if (int'(w_sel_pe) < NUM_PE) begin
            case (w_sel_byte)
                2'd0:    w_rd_byte = w_rd_acc[w_sel_pe][7:0];
                2'd1:    w_rd_byte = w_rd_acc[w_sel_pe][15:8];
                2'd2:    w_rd_byte = w_rd_acc[w_sel_pe][23:16];
                default: w_rd_byte = w_status;
            endcase
        end
    end

    assign io_tile.uo_out  = w_rd_byte;
    assign io_tile.uio_out = w_status;
    assign io_tile.uio_oe  = 8'hC0;

endmodule

`default_nettype wire

// File: tb/tb_systolic_chain.sv
// ============================================================================
// Module      : tb_systolic_chain
// Description : Self-checking bench for systolic_chain against an event-list
//               reference model of the chain (honours SYSTOLIC_SATURATE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_chain;

    localparam int NUM_PE = 4;
    localparam int ACC_W  = 24;

    localparam logic [1:0] c_NOP    = 2'b00;
    localparam logic [1:0] c_LOAD   = 2'b01;
    localparam logic [1:0] c_STREAM = 2'b10;
    localparam logic [1:0] c_CLEAR  = 2'b11;

    localparam longint c_MAX = 64'sd8388607;
    localparam longint c_MIN = -64'sd8388608;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_chain_if tt();

    systolic_chain #(.NUM_PE(NUM_PE), .ACC_W(ACC_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_tile (tt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: each streamed activation is an event tagged with the
    // edge it entered on; PE i consumes it i+1 edges later.
    typedef struct {
        logic [7:0] a;
        int         birth;
    } ent_t;

    longint     macc [NUM_PE];
    logic [7:0] mw   [NUM_PE];
    bit         movf;
    int         ecount;
    ent_t       inflight [$];

    function automatic bit m_busy();
        return inflight.size() > 0;
    endfunction

    function automatic logic [7:0] m_byte(input int p, input int b);
        logic [23:0] t;
        if (p >= NUM_PE) return 8'h00;
        if (b == 3) return {movf, m_busy(), 6'b0};
        t = macc[p][23:0];
        return t[8*b +: 8];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NUM_PE; i++) begin
            macc[i] = 0;
            mw[i]   = 8'h00;
        end
        movf = 1'b0;
        inflight.delete();
    endtask

    task automatic m_acc(input int i, input logic [7:0] a);
        longint s;
        int ai;
        int wi;
        ai = $signed(a);
        wi = $signed(mw[i]);
        s  = macc[i] + longint'(ai * wi);
`ifdef SYSTOLIC_SATURATE_EN
        if (s > c_MAX) begin
            s = c_MAX;
            movf = 1'b1;
        end else if (s < c_MIN) begin
            s = c_MIN;
            movf = 1'b1;
        end
`else
        s = s & 64'h0000_0000_00FF_FFFF;
        if (s > c_MAX) s = s - 64'sd16777216;
`endif
        macc[i] = s;
    endtask

    task automatic model_edge(input logic [1:0] op, input logic [7:0] d);
        ecount++;
        foreach (inflight[k]) begin
            int i;
            i = ecount - inflight[k].birth - 1;
            if (i >= 0 && i < NUM_PE) m_acc(i, inflight[k].a);
        end
        if (op == c_CLEAR) begin
            for (int i = 0; i < NUM_PE; i++) macc[i] = 0;
            movf = 1'b0;
            inflight.delete();
        end else begin
            if (op == c_LOAD) begin
                for (int i = NUM_PE - 1; i > 0; i--) mw[i] = mw[i-1];
                mw[0] = d;
            end
            if (op == c_STREAM) inflight.push_back('{a: d, birth: ecount});
        end
        while (inflight.size() > 0 && ecount - inflight[0].birth >= NUM_PE)
            void'(inflight.pop_front());
    endtask

    task automatic step(input logic [1:0] op, input logic [7:0] d, input logic en);
        @(negedge clk);
        tt.ena    = en;
        tt.ui_in  = d;
        tt.uio_in = {6'b000000, op};
        @(posedge clk);
        #1;
        if (en) model_edge(op, d);
        tt.ena    = 1'b0;
        tt.uio_in = 8'h00;
    endtask

    task automatic rd_byte(input int p, input int b, output logic [7:0] v);
        tt.uio_in = {2'b00, b[1:0], p[1:0], 2'b00};
        #1;
        v = tt.uo_out;
    endtask

    task automatic rd_acc(input int p, output logic [23:0] v);
        logic [7:0] b0, b1, b2;
        rd_byte(p, 0, b0);
        rd_byte(p, 1, b1);
        rd_byte(p, 2, b2);
        v = {b2, b1, b0};
    endtask

    task automatic test_reset();
        logic [7:0] v;
        for (int i = 0; i < 6; i++) step(2'($urandom_range(1, 2)), 8'($urandom), 1'b1);
        @(negedge clk);
        rst       = 1'b1;
        tt.ena    = 1'b1;
        tt.ui_in  = 8'($urandom);
        tt.uio_in = 8'h02;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        tt.ena = 1'b0;
        m_reset();
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 4; b++) begin
                rd_byte(p, b, v);
                checks++;
                if (v !== 8'h00) begin
                    failures++;
                    $display("FAIL reset_byte p=%0d b=%0d got=%h exp=00", p, b, v);
                end
            end
        end
        checks++;
        if (tt.uio_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_uio_out got=%h exp=00", tt.uio_out);
        end
        checks++;
        if (tt.uio_oe !== 8'hC0) begin
            failures++;
            $display("FAIL reset_uio_oe got=%h exp=c0", tt.uio_oe);
        end
    endtask

    task automatic test_weight_load();
        logic [23:0] v;
        step(c_LOAD, 8'h04, 1'b1);
        step(c_LOAD, 8'h03, 1'b1);
        step(c_LOAD, 8'h02, 1'b1);
        step(c_LOAD, 8'h01, 1'b1);
        step(c_STREAM, 8'h05, 1'b1);
        for (int j = 0; j <= 5; j++) begin
            if (j > 0) step(c_NOP, 8'h00, 1'b1);
            for (int p = 0; p < NUM_PE; p++) begin
                rd_acc(p, v);
                checks++;
                if (v !== macc[p][23:0]) begin
                    failures++;
                    $display("FAIL wl_acc edge=%0d p=%0d got=%h exp=%h", j, p, v, macc[p][23:0]);
                end
            end
            checks++;
            if (tt.uio_out[6] !== m_busy()) begin
                failures++;
                $display("FAIL wl_busy edge=%0d got=%b exp=%b", j, tt.uio_out[6], m_busy());
            end
        end
        for (int p = 0; p < NUM_PE; p++) begin
            rd_acc(p, v);
            checks++;
            if (v !== 24'(5 * (p + 1))) begin
                failures++;
                $display("FAIL wl_final p=%0d got=%h exp=%h", p, v, 24'(5 * (p + 1)));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] v;
        step(c_CLEAR, 8'h00, 1'b1);
        step(c_STREAM, 8'h05, 1'b1);
        step(c_STREAM, 8'hFD, 1'b1);
        for (int j = 0; j < 5; j++) step(c_NOP, 8'h00, 1'b1);
        for (int p = 0; p < NUM_PE; p++) begin
            rd_acc(p, v);
            checks++;
            if (v !== 24'(2 * (p + 1))) begin
                failures++;
                $display("FAIL b2b_acc p=%0d got=%h exp=%h", p, v, 24'(2 * (p + 1)));
            end
        end
        checks++;
        if (tt.uio_out !== 8'h00) begin
            failures++;
            $display("FAIL b2b_busy got=%h exp=00", tt.uio_out);
        end
    endtask

    task automatic test_negative();
        logic [7:0]  b;
        logic [23:0] v;
        step(c_CLEAR, 8'h00, 1'b1);
        step(c_LOAD, 8'h01, 1'b1);
        step(c_STREAM, 8'hFF, 1'b1);
        for (int j = 0; j < 5; j++) step(c_NOP, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            rd_byte(0, k, b);
            checks++;
            if (b !== 8'hFF) begin
                failures++;
                $display("FAIL neg_byte b=%0d got=%h exp=ff", k, b);
            end
        end
        rd_byte(0, 3, b);
        checks++;
        if (b !== 8'h00) begin
            failures++;
            $display("FAIL neg_status got=%h exp=00", b);
        end
        for (int p = 1; p < NUM_PE; p++) begin
            rd_acc(p, v);
            checks++;
            if (v !== macc[p][23:0]) begin
                failures++;
                $display("FAIL neg_other p=%0d got=%h exp=%h", p, v, macc[p][23:0]);
            end
        end
    endtask

    task automatic test_clear_midflight();
        logic [23:0] v;
        step(c_LOAD, 8'h04, 1'b1);
        step(c_LOAD, 8'h03, 1'b1);
        step(c_LOAD, 8'h02, 1'b1);
        step(c_LOAD, 8'h01, 1'b1);
        step(c_CLEAR, 8'h00, 1'b1);
        step(c_STREAM, 8'h05, 1'b1);
        step(c_NOP, 8'h00, 1'b1);
        checks++;
        if (tt.uio_out[6] !== 1'b1) begin
            failures++;
            $display("FAIL clr_busy_before got=%b exp=1", tt.uio_out[6]);
        end
        step(c_CLEAR, 8'h00, 1'b1);
        for (int p = 0; p < NUM_PE; p++) begin
            rd_acc(p, v);
            checks++;
            if (v !== 24'h000000) begin
                failures++;
                $display("FAIL clr_acc p=%0d got=%h exp=000000", p, v);
            end
        end
        checks++;
        if (tt.uio_out !== 8'h00) begin
            failures++;
            $display("FAIL clr_busy_after got=%h exp=00", tt.uio_out);
        end
        step(c_STREAM, 8'h05, 1'b1);
        for (int j = 0; j < 5; j++) step(c_NOP, 8'h00, 1'b1);
        for (int p = 0; p < NUM_PE; p++) begin
            rd_acc(p, v);
            checks++;
            if (v !== 24'(5 * (p + 1))) begin
                failures++;
                $display("FAIL clr_restream p=%0d got=%h exp=%h", p, v, 24'(5 * (p + 1)));
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [7:0] v;
        int         p, b;
        for (int n = 0; n < 300; n++) begin
            op = 2'($urandom_range(0, 3));
            if (op == c_CLEAR && ($urandom % 6) != 0) op = c_STREAM;
            step(op, 8'($urandom), 1'(($urandom % 8) != 0));
            p = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            rd_byte(p, b, v);
            checks++;
            if (v !== m_byte(p, b)) begin
                failures++;
                $display("FAIL rnd_byte n=%0d p=%0d b=%0d got=%h exp=%h", n, p, b, v, m_byte(p, b));
            end
            checks++;
            if (tt.uio_out !== {movf, m_busy(), 6'b0}) begin
                failures++;
                $display("FAIL rnd_uio_out n=%0d got=%h exp=%h", n, tt.uio_out, {movf, m_busy(), 6'b0});
            end
        end
    endtask

    task automatic test_overflow();
        logic [23:0] v0, v1, vexp;
        logic        oexp;
        step(c_CLEAR, 8'h00, 1'b1);
        step(c_LOAD, 8'h80, 1'b1);
        for (int n = 0; n < 512; n++) begin
            if (n == 256) begin
                rd_acc(0, v0);
                checks++;
                if (v0 !== 24'h3FC000) begin
                    failures++;
                    $display("FAIL ovf_mid got=%h exp=3fc000", v0);
                end
                for (int k = 0; k < 4; k++) step(c_STREAM, 8'h80, 1'b0);
                rd_acc(0, v1);
                checks++;
                if (v1 !== 24'h3FC000) begin
                    failures++;
                    $display("FAIL ovf_freeze got=%h exp=3fc000", v1);
                end
                checks++;
                if (tt.uio_out[6] !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_freeze_busy got=%b exp=1", tt.uio_out[6]);
                end
            end
            step(c_STREAM, 8'h80, 1'b1);
        end
        for (int j = 0; j < 5; j++) step(c_NOP, 8'h00, 1'b1);
`ifdef SYSTOLIC_SATURATE_EN
        vexp = 24'h7FFFFF;
        oexp = 1'b1;
`else
        vexp = 24'h800000;
        oexp = 1'b0;
`endif
        rd_acc(0, v0);
        checks++;
        if (v0 !== vexp || v0 !== macc[0][23:0]) begin
            failures++;
            $display("FAIL ovf_acc0 got=%h exp=%h", v0, vexp);
        end
        checks++;
        if (tt.uio_out[7] !== oexp) begin
            failures++;
            $display("FAIL ovf_flag got=%b exp=%b", tt.uio_out[7], oexp);
        end
        for (int p = 1; p < NUM_PE; p++) begin
            rd_acc(p, v1);
            checks++;
            if (v1 !== macc[p][23:0]) begin
                failures++;
                $display("FAIL ovf_other p=%0d got=%h exp=%h", p, v1, macc[p][23:0]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        tt.ena    = 1'b0;
        tt.ui_in  = 8'h00;
        tt.uio_in = 8'h00;
        ecount    = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_weight_load();
        test_back_to_back();
        test_negative();
        test_clear_midflight();
        test_random();
        test_overflow();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/systolic_chain.md
Name: systolic_chain

Overview:
- Weight-stationary 1-D systolic chain of NUM_PE signed 8x8 multiply-accumulate processing elements.
- Packaged as a TinyTapeout user tile.
- Weights are shifted in serially. Activations stream down the chain one PE per cycle.
- Any PE accumulator byte is read out through uo_out using a byte mux controlled by uio_in.

Parameters:
- NUM_PE, 4, number of PEs in the chain (1..4; addressed by a 2-bit select).
- ACC_W, 24, signed accumulator width per PE (16..24).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  tile enable; when 0 all state holds.
- ui_in  in  8  data: weight (LOAD_W) or signed activation (STREAM).
- uio_in  in  8  control: [1:0] op, [3:2] PE select, [5:4] byte select, [7:6] unused.
- uo_out  out  8  readout byte.
- uio_out  out  8  [7] overflow flag, [6] pipeline busy, [5:0] = 0.
- uio_oe  out  8  constant 8'hC0.

Behaviour:
- All state updates on the rising clk edge, only when ena=1. Reset has priority over ena.
- Reset: weights, activation registers, valid bits, accumulators and ovf all cleared to 0.
- op encoding:
  - 00 NOP.
  - 01 LOAD_W: w[0]<=ui_in, w[i]<=w[i-1]. The first weight loaded ends in PE NUM_PE-1 after NUM_PE loads.
  - 10 STREAM: a[0]<=ui_in, v[0]<=1.
  - 11 CLEAR: all acc, v and ovf go to 0; weights retained; a[] contents don't care.
- Activation pipeline shifts every enabled edge regardless of op: a[i]<=a[i-1], v[i]<=v[i-1]. v[0]<=0 unless op=STREAM.
- MAC, each enabled edge, for each PE with v[i]=1: acc[i] <= acc[i] + sext(a[i]*w[i]).
  - Uses pre-edge a[i] and w[i].
  - Operands signed 8-bit; product signed 16-bit.
- Latency: an activation presented with STREAM on edge k updates acc[i] on edge k+1+i.
- CLEAR takes priority over MAC on the same edge. CLEAR also kills all in-flight activations.
- Default arithmetic: two's-complement wrap modulo 2^ACC_W; ovf stays 0.
- Readout: uo_out is combinational from registered state.
  - Selected PE p = uio_in[3:2], byte b = uio_in[5:4].
  - b=0,1,2: byte b of sext(acc[p]) to 24 bits.
  - b=3: status {ovf, |v, 6'b0}.
  - p >= NUM_PE reads 8'h00.
- uio_out[6] = |v (busy). uio_out[7] = ovf.

Optional Feature:
- Macro SYSTOLIC_SATURATE_EN.
- Defined:
  - Accumulation saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Any clamp event sets sticky ovf; ovf clears only on reset or CLEAR.
- Undefined: wrap arithmetic; ovf is constant 0.

Test Plan:
- Reset with ena=1 -> every PE/byte reads 00; uio_out=00; uio_oe=C0.
- Weight load and single stream:
  - LOAD_W 04,03,02,01 (w0..w3 = 1..4), then STREAM 05, then NOPs.
  - Required: acc0=5 at k+1, acc1=10 at k+2, acc2=15 at k+3, acc3=20 at k+4; busy high during flight, low after.
- Back-to-back streams: STREAM 05 then FD (-3) on consecutive edges -> final acc = 2, 4, 6, 8.
- Negative readout and status byte:
  - w0=01, STREAM FF -> PE0 bytes 0..2 = FF, FF, FF.
  - Byte 3 = 00 after drain.
- CLEAR mid-flight: CLEAR while the pipeline is busy -> all acc 0, busy 0, weights intact (re-stream 05 gives 5/10/15/20).
- Overflow (ena toggled low mid-run must freeze state):
  - w0=80, 512 x STREAM 80.
  - With SYSTOLIC_SATURATE_EN: acc0 = 7FFFFF, ovf=1.
  - Without SYSTOLIC_SATURATE_EN: acc0 = 800000, ovf=0.
